// File: rtl/mode_sel_pkg.sv
// rtl/mode_sel_pkg.sv - shared defaults, width helper and encodings for the mode selector
//
// Contents:
//   NUM_MODES_DEF / DEB_CYC_DEF : default parameter values for mode_sel_fsm
//   WRAP_SAT / WRAP_ON          : values of the WRAP parameter
//   btn_ev_e                    : combined press-event classification for one cycle
//   mw_of()                     : mode index width, never less than one bit
package mode_sel_pkg;

    localparam int NUM_MODES_DEF = 2;
    localparam int DEB_CYC_DEF   = 4;

    localparam int WRAP_SAT = 0;
    localparam int WRAP_ON  = 1;

    typedef enum logic [1:0] {
        EV_NONE = 2'b00,
        EV_NEXT = 2'b01,
        EV_PREV = 2'b10,
        EV_BOTH = 2'b11
    } btn_ev_e;

    function automatic int mw_of(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - 2-flop synchroniser, stable-count debouncer and press detector
//
// Ports:
//   clk   : system clock, rising edge
//   rst   : asynchronous active-low reset
//   btn   : raw asynchronous button level, 1 = pressed
//   press : one-cycle pulse on each 0->1 transition of the debounced level
module btn_debounce #(
    parameter int DEB_CYC = mode_sel_pkg::DEB_CYC_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    // The counter only needs to reach DEB_CYC-1: the edge that would make it
    // DEB_CYC is the edge that accepts the new level instead.
    localparam int CW = (DEB_CYC < 2) ? 1 : $clog2(DEB_CYC);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYC - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic          level_prev;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            level      <= 1'b0;
            level_prev <= 1'b0;
            cnt        <= '0;
        end else begin
            sync1      <= btn;
            sync2      <= sync1;
            level_prev <= level;
            // Counting cycles that disagree with the accepted level is the same
            // as counting a stable run: any change back restarts from zero.
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // Releases fall through silently; only a rising debounced level is an event.
    assign press = level & ~level_prev;

endmodule

// File: rtl/mode_sel_fsm.sv
// rtl/mode_sel_fsm.sv - two-button mode selector with wrap or saturate at the ends
//
// Ports:
//   clk         : system clock, rising edge
//   rst         : asynchronous active-low reset
//   btn_next    : raw button level, 1 = pressed, steps mode up
//   btn_prev    : raw button level, 1 = pressed, steps mode down
//   mode        : current mode index (registered)
//   mode_onehot : one-hot decode of mode (registered)
//   mode_chg    : one-cycle pulse in the cycle a new mode value first appears
module mode_sel_fsm
    import mode_sel_pkg::*;
#(
    parameter int NUM_MODES = NUM_MODES_DEF,
    parameter int DEB_CYC   = DEB_CYC_DEF,
    parameter int WRAP      = WRAP_ON,
    localparam int MW       = mw_of(NUM_MODES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 btn_next,
    input  logic                 btn_prev,
    output logic [MW-1:0]        mode,
    output logic [NUM_MODES-1:0] mode_onehot,
    output logic                 mode_chg
);

    localparam logic [MW-1:0] LAST_MODE = MW'(NUM_MODES - 1);

    logic                 press_next;
    logic                 press_prev;
    btn_ev_e              ev;
    logic [MW-1:0]        mode_nxt;
    logic [NUM_MODES-1:0] onehot_nxt;
    logic                 chg_nxt;

    btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_next (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_next),
        .press (press_next)
    );

    btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_prev (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_prev),
        .press (press_prev)
    );

    always_comb begin
        ev         = btn_ev_e'({press_prev, press_next});
        mode_nxt   = mode;
        case (ev)
            EV_NEXT: begin
                if (mode == LAST_MODE) begin
                    mode_nxt = (WRAP == WRAP_ON) ? '0 : mode;
                end else begin
                    mode_nxt = mode + MW'(1);
                end
            end
            EV_PREV: begin
                if (mode == '0) begin
                    mode_nxt = (WRAP == WRAP_ON) ? LAST_MODE : mode;
                end else begin
                    mode_nxt = mode - MW'(1);
                end
            end
            // Simultaneous presses cancel; nothing to do for EV_BOTH/EV_NONE.
            default: mode_nxt = mode;
        endcase
        onehot_nxt = NUM_MODES'(1) << mode_nxt;
        // Comparing values (not events) keeps a saturated hold silent.
        chg_nxt    = (mode_nxt != mode);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode        <= '0;
            mode_onehot <= NUM_MODES'(1);
            mode_chg    <= 1'b0;
        end else begin
            mode        <= mode_nxt;
            mode_onehot <= onehot_nxt;
            mode_chg    <= chg_nxt;
        end
    end

endmodule

// File: doc/mode_sel_fsm.md
MODE_SEL_FSM -- requirements
Module: mode_sel_fsm

Interface
REQ-001 The block SHALL have parameter NUM_MODES, default 2, number of selectable modes (legal range 2..16).
REQ-002 The block SHALL have parameter DEB_CYC, default 4, number of consecutive stable cycles required to accept a button level (legal range 1..65535).
REQ-003 The block SHALL have parameter WRAP, default 1; 1 means wrap-around at the ends, 0 means saturate at the ends.
REQ-004 The block SHALL define local width MW = max(1, clog2(NUM_MODES)).
REQ-005 The block SHALL have port clk, input, 1 bit, system clock; all state SHALL update on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit, asynchronous active-low reset.
REQ-007 The block SHALL have port btn_next, input, 1 bit, raw asynchronous button level; 1 means pressed.
REQ-008 The block SHALL have port btn_prev, input, 1 bit, raw asynchronous button level; 1 means pressed.
REQ-009 The block SHALL have port mode, output, MW bits, current mode index.
REQ-010 The block SHALL have port mode_onehot, output, NUM_MODES bits, one-hot decode of mode.
REQ-011 The block SHALL have port mode_chg, output, 1 bit, one-cycle pulse asserted in the same cycle the new mode value first appears.

Function
REQ-012 Each btn input SHALL pass through a 2-flop synchroniser.
REQ-013 Each synchronised input SHALL feed a debouncer: a counter that clears on any change of the synchronised level and counts consecutive stable cycles; the debounced level SHALL take the new value once the counter reaches DEB_CYC.
REQ-014 A press event SHALL be a 0->1 transition of the debounced level and SHALL last exactly one cycle; releases SHALL generate no event.
REQ-015 A raw level held stable SHALL produce its mode update exactly DEB_CYC+3 rising edges after the first edge that samples it.
REQ-016 On a next-only event: with WRAP=1, mode SHALL become 0 if mode==NUM_MODES-1, else mode+1; with WRAP=0, mode SHALL hold at NUM_MODES-1.
REQ-017 On a prev-only event: with WRAP=1, mode SHALL become NUM_MODES-1 if mode==0, else mode-1; with WRAP=0, mode SHALL hold at 0.
REQ-018 If next and prev events occur in the same cycle, mode SHALL NOT change and mode_chg SHALL NOT pulse.
REQ-019 mode_chg SHALL pulse only when mode actually changes, so a saturated hold produces no pulse.
REQ-020 mode, mode_onehot and mode_chg SHALL be registered outputs with no combinational path from the btn inputs.
REQ-021 A bounce shorter than DEB_CYC cycles SHALL produce no event.
REQ-022 Holding a button SHALL produce exactly one event; there is no auto-repeat.

Reset
REQ-023 While rst==0, the block SHALL force mode=0, mode_onehot=1 (bit 0 set), mode_chg=0, synchronisers=0, debounced levels=0 and counters=0.
REQ-024 A reset asserted mid-debounce SHALL discard the pending event.
REQ-025 A button held through reset release SHALL produce one event DEB_CYC+3 edges after release.

Structure
REQ-026 The debouncer with edge detect SHALL be the sub-module btn_debounce, parameterised by DEB_CYC, instantiated twice.
REQ-027 The shared package mode_sel_pkg SHALL hold the NUM_MODES/DEB_CYC defaults, the MW width function and the WRAP encoding constants.
REQ-028 The total RTL size SHALL be approximately 150-250 lines.

Verification (NUM_MODES=3, DEB_CYC=4, WRAP=1 unless stated)
REQ-029 After reset release: mode=0, mode_onehot=3'b001, mode_chg=0.
REQ-030 Holding btn_next high for 10 cycles SHALL set mode=1 exactly at edge 7 with a single mode_chg pulse; three separate presses SHALL step mode 1, 2, 0 (wrap).
REQ-031 btn_prev from mode=0 SHALL give mode=2; with WRAP=0, btn_prev from mode=0 SHALL keep mode=0 with no mode_chg pulse.
REQ-032 A 3-cycle glitch on btn_next SHALL leave mode unchanged; a pattern of 1,0,1 followed by a stable 1 SHALL produce one event counted from the final stable edge.
REQ-033 btn_next and btn_prev rising on the same edge and held SHALL leave mode unchanged with no mode_chg pulse.
REQ-034 Pulling rst low 2 cycles into a press SHALL produce mode=0 and no event; a button held across reset release SHALL produce one event 7 edges after release.
